// File: rtl/a_sqrtb_gen_pkg.sv
// Shared types and width/latency helpers for the a*isqrt(b) unit.
package a_sqrtb_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SQRT,
        ROUND,
        MUL,
        DONE
    } state_e;

    function automatic int sq_width(input int b_w);
        return b_w / 2 + 1;
    endfunction

    function automatic int y_width(input int a_w, input int b_w);
        return a_w + sq_width(b_w);
    endfunction

    function automatic int latency(input int b_w);
        return b_w + 3;
    endfunction

endpackage

// File: rtl/a_sqrtb_gen_isqrt.sv
// Restoring digit-by-digit integer square root, one root bit per cycle, MSB first.
module isqrt_iter #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   rad_i,
    output logic           done_o,
    output logic [W/2-1:0] root_o,
    output logic [W/2:0]   rem_o
);

    localparam int HW = W / 2;
    localparam int CW = $clog2(HW) + 1;

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rad_q, rad_d;
    logic [HW-1:0] root_q, root_d;
    logic [HW:0]   rem_q, rem_d;
    logic [HW+2:0] part_t, trial_t;

    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        rad_d   = rad_q;
        root_d  = root_q;
        rem_d   = rem_q;
        // Bring down the next bit pair and try subtracting (4*root + 1).
        part_t  = {rem_q, rad_q[W-1 -: 2]};
        trial_t = {1'b0, root_q, 2'b01};
        if (start_i) begin
            run_d  = 1'b1;
            cnt_d  = CW'(HW - 1);
            rad_d  = rad_i;
            root_d = '0;
            rem_d  = '0;
        end else if (run_q) begin
            if (part_t >= trial_t) begin
                rem_d  = (HW+1)'(part_t - trial_t);
                root_d = (root_q << 1) | HW'(1);
            end else begin
                rem_d  = (HW+1)'(part_t);
                root_d = root_q << 1;
            end
            rad_d = rad_q << 2;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rad_q  <= '0;
            root_q <= '0;
            rem_q  <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            rad_q  <= rad_d;
            root_q <= root_d;
            rem_q  <= rem_d;
        end
    end

    // High during the last iteration; root/rem are final after this edge.
    assign done_o = run_q && (cnt_q == '0);
    assign root_o = root_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/a_sqrtb_gen.sv
// y = a * isqrt(b) with floor or round-to-nearest root: iterative sqrt then shift-add multiply.
module a_sqrtb_gen
    import a_sqrtb_gen_pkg::*;
#(
    parameter  int A_W  = 8,
    parameter  int B_W  = 8,
    localparam int SQ_W = sq_width(B_W),
    localparam int Y_W  = y_width(A_W, B_W)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [A_W-1:0] a_bi,
    input  logic [B_W-1:0] b_bi,
    input  logic           mode_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           y_valid_o,
    output logic [Y_W-1:0] y_bo
);

    localparam int HW  = B_W / 2;
    localparam int MCW = $clog2(SQ_W) + 1;

    // Handshake: start_i is taken on any edge where busy_o=0 (IDLE or DONE);
    // while busy_o=1 it is ignored. y_valid_o pulses for the single DONE cycle.
    state_e         state_q, state_d;
    logic [A_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic           mode_q, mode_d;
    logic           sq_start_q, sq_start_d;
    logic [Y_W-1:0] mcand_q, mcand_d;
    logic [SQ_W-1:0] mplier_q, mplier_d;
    logic [Y_W-1:0] acc_q, acc_d;
    logic [MCW-1:0] mcnt_q, mcnt_d;
    logic [Y_W-1:0] y_q, y_d;

    logic           sq_done;
    logic [HW-1:0]  sq_root;
    logic [HW:0]    sq_rem;
    logic           round_up;
    logic [SQ_W-1:0] r_rnd;
    logic [Y_W-1:0] acc_sum;

    isqrt_iter #(.W(B_W)) u_isqrt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (sq_start_q),
        .rad_i   (b_q),
        .done_o  (sq_done),
        .root_o  (sq_root),
        .rem_o   (sq_rem)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        sq_start_d = 1'b0;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        mcnt_d     = mcnt_q;
        y_d        = y_q;
        // rem > r means b is closer to (r+1)^2 than to r^2.
        round_up   = mode_q && (sq_rem > {1'b0, sq_root});
        r_rnd      = SQ_W'(sq_root) + SQ_W'(round_up);
        acc_sum    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_d        = a_bi;
                    b_d        = b_bi;
                    mode_d     = mode_i;
                    sq_start_d = 1'b1;
                    state_d    = SQRT;
                end else begin
                    state_d = IDLE;
                end
            end
            SQRT: begin
                if (sq_done) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                mcand_d  = Y_W'(a_q);
                mplier_d = r_rnd;
                acc_d    = '0;
                mcnt_d   = MCW'(SQ_W - 1);
                state_d  = MUL;
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                mcnt_d   = mcnt_q - MCW'(1);
                if (mcnt_q == '0) begin
                    y_d     = acc_sum;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            sq_start_q <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mcnt_q     <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            sq_start_q <= sq_start_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            mcnt_q     <= mcnt_d;
            y_q        <= y_d;
        end
    end

    assign busy_o    = (state_q == SQRT) || (state_q == ROUND) || (state_q == MUL);
    assign y_valid_o = (state_q == DONE);
    assign y_bo      = y_q;

endmodule

// File: tb/tb_a_sqrtb_gen.sv
// Self-checking bench for a_sqrtb_gen: directed corner cases plus random operands vs. an arithmetic model.
module tb_a_sqrtb_gen;
    import a_sqrtb_gen_pkg::*;

    localparam int A_W = 8;
    localparam int B_W = 8;
    localparam int Y_W = y_width(A_W, B_W);
    localparam int L   = latency(B_W);

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [A_W-1:0] a_bi;
    logic [B_W-1:0] b_bi;
    logic           mode_i;
    logic           start_i;
    logic           busy_o;
    logic           y_valid_o;
    logic [Y_W-1:0] y_bo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    a_sqrtb_gen #(.A_W(A_W), .B_W(B_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .a_bi      (a_bi),
        .b_bi      (b_bi),
        .mode_i    (mode_i),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .y_valid_o (y_valid_o),
        .y_bo      (y_bo)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: largest r with r*r <= b, bumped by one when rounding and b - r*r > r.
    function automatic int ref_y(input int a, input int b, input bit mode);
        int r = 0;
        while ((r + 1) * (r + 1) <= b) r++;
        if (mode && (b - r * r) > r) r++;
        return a * r;
    endfunction

    // Drives one start pulse; returns at the falling edge right after the start edge (k=0).
    task automatic launch(input int a, input int b, input bit mode);
        @(negedge clk_i);
        a_bi    = A_W'(a);
        b_bi    = B_W'(b);
        mode_i  = mode;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        a_bi    = A_W'($urandom);
        b_bi    = B_W'($urandom);
        mode_i  = 1'($urandom_range(0, 1));
    endtask

    // Called at k=0; returns at the falling edge where y_valid_o is seen (or lat=-1 on timeout).
    task automatic wait_done(output int lat, output int busy_n, output int busy_at_done,
                             output logic [Y_W-1:0] y);
        lat          = -1;
        busy_n       = 0;
        busy_at_done = 1;
        y            = '0;
        for (int k = 0; k < 40; k++) begin
            if (y_valid_o) begin
                lat          = k;
                y            = y_bo;
                busy_at_done = int'(busy_o);
                return;
            end
            if (busy_o) busy_n++;
            @(negedge clk_i);
        end
    endtask

    task automatic run_check(input string tag, input int a, input int b, input bit mode, input int exp);
        int lat, busy_n, busy_at_done;
        logic [Y_W-1:0] y;
        launch(a, b, mode);
        wait_done(lat, busy_n, busy_at_done, y);
        check_val({tag, " y"}, 32'(y), exp);
        check_val({tag, " latency"}, lat, L);
        check_val({tag, " busy cycles"}, busy_n, L);
        check_val({tag, " busy in done"}, busy_at_done, 0);
    endtask

    int da[9]  = '{3, 255, 255, 1, 1, 1, 1, 1, 0};
    int db[9]  = '{16, 255, 255, 2, 3, 6, 12, 0, 200};
    bit dm[9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
    int dy[9]  = '{12, 3825, 4080, 1, 2, 2, 3, 0, 0};

    initial begin
        int lat, busy_n, busy_at_done, pulses, ra, rb;
        bit rm;
        logic [Y_W-1:0] y, y_first;

        rst_i   = 1'b1;
        start_i = 1'b0;
        a_bi    = '0;
        b_bi    = '0;
        mode_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("reset busy", 32'(busy_o), 0);
        check_val("reset valid", 32'(y_valid_o), 0);
        check_val("reset y", 32'(y_bo), 0);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("directed%0d", i), da[i], db[i], dm[i], dy[i]);
        end

        // Starts while busy must be ignored.
        launch(5, 9, 0);
        pulses  = 0;
        y_first = '0;
        lat     = -1;
        for (int k = 0; k < 30; k++) begin
            if (y_valid_o) begin
                if (pulses == 0) begin
                    y_first = y_bo;
                    lat     = k;
                end
                pulses++;
            end
            if (k == 3 || k == 6) begin
                start_i = 1'b1;
                a_bi    = 8'd7;
                b_bi    = 8'd100;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        check_val("ignore pulses", pulses, 1);
        check_val("ignore y", 32'(y_first), 15);
        check_val("ignore latency", lat, L);

        // Back-to-back: second start lands in the DONE cycle.
        launch(2, 25, 0);
        wait_done(lat, busy_n, busy_at_done, y);
        check_val("b2b first y", 32'(y), 10);
        check_val("b2b first latency", lat, L);
        check_val("b2b busy in done", busy_at_done, 0);
        a_bi    = 8'd4;
        b_bi    = 8'd64;
        mode_i  = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        a_bi    = A_W'($urandom);
        b_bi    = B_W'($urandom);
        check_val("b2b busy after done", 32'(busy_o), 1);
        wait_done(lat, busy_n, busy_at_done, y);
        check_val("b2b second y", 32'(y), 32);
        check_val("b2b second latency", lat, L);
        check_val("b2b second busy cycles", busy_n, L);

        // Reset in the middle of the multiply phase.
        launch(9, 49, 1);
        repeat (8) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_val("abort busy", 32'(busy_o), 0);
        check_val("abort y", 32'(y_bo), 0);
        check_val("abort valid", 32'(y_valid_o), 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (y_valid_o) pulses++;
            @(negedge clk_i);
        end
        check_val("abort no pulse", pulses, 0);
        run_check("after abort", 9, 49, 1, 63);

        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       rb = int'($urandom_range(0, 15)) ** 2;
                1:       rb = 255 - int'($urandom_range(0, 3));
                default: rb = int'($urandom_range(0, 255));
            endcase
            rm = 1'($urandom_range(0, 1));
            run_check($sformatf("rand%0d a=%0d b=%0d m=%0d", i, ra, rb, rm), ra, rb, rm, ref_y(ra, rb, rm));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

endmodule
